// File: rtl/reg_shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// reg_shift_sequencer_if
// Bundles the request/response signals of the register-specified shift
// sequencer so the execute stage and the sequencer connect through one port.
//
//   start       request pulse (sampled only while the sequencer is idle)
//   val_rm      operand to be shifted (Rm)
//   shift_amt   shift amount, Rs[7:0]
//   shift_mode  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   carry_in    current C flag
//   busy        pipeline stall, high while an operation is in flight
//   done        one-cycle completion pulse
//   result      shifted value, valid with done, held until the next start
//   carry_out   shifter carry, held like result
//   err         pulses with done for an unsupported mode
//
// master: the execute-stage requester.  slave: the sequencer.
// -----------------------------------------------------------------------------
interface reg_shift_sequencer_if;
   logic        start;
   logic [31:0] val_rm;
   logic [7:0]  shift_amt;
   logic [1:0]  shift_mode;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;
   logic        err;

   modport master (
      output start, val_rm, shift_amt, shift_mode, carry_in,
      input  busy, done, result, carry_out, err
   );

   modport slave (
      input  start, val_rm, shift_amt, shift_mode, carry_in,
      output busy, done, result, carry_out, err
   );
endinterface

// File: rtl/reg_shift_sequencer.sv
// -----------------------------------------------------------------------------
// reg_shift_sequencer
// Multi-cycle generator of the second ALU operand for register-specified
// shifts. An accepted start captures the operand and iterates the shift in
// steps of at most STEP bits per cycle, stalling the pipeline through busy,
// then presents result/carry_out with a one-cycle done pulse.
//
// Parameters:
//   STEP  maximum shift distance per cycle (1, 2, 4, 8 or 16)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   reg_shift_sequencer_if.slave (start/operands in, busy/done/result/
//         carry_out/err out)
// Configuration macro:
//   REG_SHIFT_ROR_EN  defined: ROR datapath built, err always 0.
//                     undefined: mode 11 completes at once with the operand and
//                     carry_in passed through and err raised with done.
// -----------------------------------------------------------------------------
module reg_shift_sequencer #(
   parameter int unsigned STEP = 8
) (
   input logic                 clk,
   input logic                 rst,
   reg_shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [5:0] STEP_W = 6'(STEP);

   state_t      state_r;
   state_t      state_s;

   logic [31:0] work_r;       // working value; doubles as the result output
   logic        carry_r;      // running shifter carry; doubles as carry_out
   logic [5:0]  rem_r;        // shift distance still to apply
   logic [1:0]  mode_r;
   logic        busy_r;
   logic        done_r;
   logic        err_r;

   logic [5:0]  start_rem_s;
   logic        unsupported_s;
   logic [5:0]  step_s;
   logic [5:0]  rem_next_s;
   logic [32:0] lsl_s;
   logic [32:0] lsr_s;
   logic signed [32:0] asr_s;
`ifdef REG_SHIFT_ROR_EN
   logic [31:0] ror_s;
`endif
   logic [31:0] work_next_s;
   logic        carry_next_s;

   // Decode the distance to apply for a new request; LSL/LSR/ASR clamp at 33
   // so that every amount of 33 or more yields the ARM-defined result.
   always_comb begin
      start_rem_s   = 6'd0;
      unsupported_s = 1'b0;
      case (bus.shift_mode)
         2'b11: begin
`ifdef REG_SHIFT_ROR_EN
            start_rem_s = {1'b0, bus.shift_amt[4:0]};
`else
            unsupported_s = 1'b1;
`endif
         end
         default: begin
            if (bus.shift_amt > 8'd33) begin
               start_rem_s = 6'd33;
            end else begin
               start_rem_s = bus.shift_amt[5:0];
            end
         end
      endcase
   end

   // One bounded shift step. The extra bit in the 33-bit forms catches the
   // last bit shifted out, which becomes the carry.
   always_comb begin
      if (rem_r > STEP_W) begin
         step_s = STEP_W;
      end else begin
         step_s = rem_r;
      end
      rem_next_s = rem_r - step_s;
      lsl_s      = {carry_r, work_r} << step_s;
      lsr_s      = {work_r, carry_r} >> step_s;
      // ASR keeps bit 31 unchanged every step, so it stays the original sign.
      asr_s      = $signed({work_r, carry_r}) >>> step_s;
`ifdef REG_SHIFT_ROR_EN
      ror_s      = (work_r >> step_s) | (work_r << (6'd32 - step_s));
`endif
      work_next_s  = work_r;
      carry_next_s = carry_r;
      case (mode_r)
         2'b00: begin
            work_next_s  = lsl_s[31:0];
            carry_next_s = lsl_s[32];
         end
         2'b01: begin
            work_next_s  = lsr_s[32:1];
            carry_next_s = lsr_s[0];
         end
         2'b10: begin
            work_next_s  = asr_s[32:1];
            carry_next_s = asr_s[0];
         end
         2'b11: begin
`ifdef REG_SHIFT_ROR_EN
            work_next_s  = ror_s;
            carry_next_s = ror_s[31];
`else
            work_next_s  = work_r;
            carry_next_s = carry_r;
`endif
         end
         default: begin
            work_next_s  = work_r;
            carry_next_s = carry_r;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (start_rem_s != 6'd0) begin
                  state_s = SHIFT;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (rem_next_s == 6'd0) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_r  <= 32'h0000_0000;
         carry_r <= 1'b0;
         rem_r   <= 6'd0;
         mode_r  <= 2'b00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
         done_r <= (state_s == DONE);
         err_r  <= (state_r == IDLE) && bus.start && unsupported_s;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  work_r <= bus.val_rm;
                  rem_r  <= start_rem_s;
                  mode_r <= bus.shift_mode;
                  // A nonzero ROR by a multiple of 32 reports bit 31; a nonzero
                  // remaining distance overwrites this carry on every step.
                  if ((bus.shift_mode == 2'b11) && (bus.shift_amt != 8'd0) && !unsupported_s) begin
                     carry_r <= bus.val_rm[31];
                  end else begin
                     carry_r <= bus.carry_in;
                  end
               end
            end
            SHIFT: begin
               work_r  <= work_next_s;
               carry_r <= carry_next_s;
               rem_r   <= rem_next_s;
            end
            default: begin
               work_r <= work_r;
            end
         endcase
      end
   end

   assign bus.result    = work_r;
   assign bus.carry_out = carry_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;

endmodule

// File: doc/reg_shift_sequencer.md
# reg_shift_sequencer

Multi-cycle sequencer that produces the second ALU operand for register-specified shifts (shift amount taken from Rs[7:0]), which the single-cycle operand generator does not cover. It sits beside the operand generator in the execute stage. It accepts one operation per start pulse and stalls the pipeline through `busy` while it iterates the shift in bounded steps. It returns the shifted value and shifter carry-out with a one-cycle `done` pulse.

## Interface
- `STEP`, default 8: maximum shift distance applied per cycle. Legal values are 1, 2, 4, 8 and 16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `val_rm` input 32: operand to be shifted (Rm value).
- `shift_amt` input 8: shift amount, Rs[7:0].
- `shift_mode` input 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `carry_in` input 1: current C flag; returned as carry when the amount is 0.
- `busy` output 1: high whenever state ≠ IDLE; used as the pipeline stall.
- `done` output 1: one-cycle pulse; `result`/`carry_out` are valid in that cycle.
- `result` output 32: shifted value; holds until the next accepted start.
- `carry_out` output 1: shifter carry; holds like `result`.
- `err` output 1: pulses with `done` for an unsupported mode (see Configuration).

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE, `start`=1: capture the operand, mode and carry_in, and compute `rem` (6 bits):
  - LSL, LSR, ASR: `rem` = min(`shift_amt`, 33).
  - ROR: `rem` = `shift_amt`[4:0].
- From IDLE, the next state is SHIFT if `rem` ≠ 0, otherwise DONE.
- Amount-0 cases load the final result directly and go to DONE:
  - `shift_amt`=0, any mode: `result` = `val_rm`, `carry_out` = `carry_in`.
  - ROR with `shift_amt` ≠ 0 and `shift_amt`[4:0] = 0: `result` = `val_rm`, `carry_out` = `val_rm`[31].
- SHIFT: each cycle, shift the working register by s = min(`rem`, `STEP`) using the captured mode, then `rem` -= s.
  - LSL fills with 0; `carry_out` = last bit shifted out of bit 31.
  - LSR fills with 0; `carry_out` = last bit shifted out of bit 0.
  - ASR fills with the original bit 31; `carry_out` = last bit shifted out of bit 0.
  - ROR rotates right; `carry_out` = new bit 31.
- The 33 clamp makes ≥33 shifts ARM-correct:
  - LSL/LSR by ≥33 give result 0, carry 0.
  - LSL/LSR by exactly 32 give result 0, carry = bit 0 (LSL) or bit 31 (LSR).
  - ASR by ≥32 gives all bits equal to the sign bit, carry = sign bit.
- When `rem` reaches 0 after a step, the next state is DONE.
- DONE: `done`=1 for exactly one cycle, then go unconditionally to IDLE.
- `start` in SHIFT or DONE is ignored: no queueing and no effect on the operation in flight.
- Reset at any cycle, including mid-SHIFT, aborts the operation. The next cycle is IDLE with all outputs at reset values.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `err`=0, `result`=32'h0, `carry_out`=0.
- Start sampled at edge k, with n = `rem`:
  - n=0: `done` is high in cycle k+1.
  - n>0: `done` is high in cycle k+1+ceil(n/`STEP`).
- `busy` rises in the cycle after the accepting edge and falls in the cycle after `done`.
- Back-to-back operation: a new `start` can be accepted in the IDLE cycle immediately after DONE. Peak throughput is one operation per 2+ceil(n/`STEP`) cycles.
- Worst case at `STEP`=8: n=33, `done` at k+6.

## Configuration
- Macro: `REG_SHIFT_ROR_EN`.
- Defined: ROR is implemented as above; `err` is always 0.
- Undefined: mode 11 is unsupported and the ROR datapath is not built.
  - Mode 11 goes straight IDLE → DONE.
  - `result` = `val_rm`, `carry_out` = `carry_in`.
  - `err`=1 together with `done`.

## Test plan
All scenarios use `STEP`=8, `REG_SHIFT_ROR_EN` defined unless stated, and start accepted at edge k.
- LSL, `val_rm`=0x00000001, amt 4 → `result`=0x00000010, `carry_out`=0, `done` at k+2.
- LSR, `val_rm`=0x80000000, amt 32 → `result`=0x00000000, `carry_out`=1, `done` at k+5.
- ASR, `val_rm`=0x80000000, amt 200 → `result`=0xFFFFFFFF, `carry_out`=1, `done` at k+6.
- ROR, `val_rm`=0x000000F1, amt 4 → `result`=0x1000000F, `carry_out`=0, `done` at k+2.
- ROR, `val_rm`=0x80000001, amt 32 → `result`=0x80000001, `carry_out`=1, `done` at k+1.
- Amt 0, `carry_in`=1 → `result`=`val_rm`, `carry_out`=1, `done` at k+1.
- Extra `start` pulses during SHIFT → ignored; the in-flight result is unchanged.
- `rst` asserted at k+2 of an amt-33 operation → IDLE next cycle, all outputs 0, no `done`.
- Without `REG_SHIFT_ROR_EN`: mode 11, `val_rm`=0x12345678, `carry_in`=0 → `result`=0x12345678, `carry_out`=0, `err`=1 with `done` at k+1.
